// File: rtl/ysyx_22041211_axi_lite_sram_rw.sv
// AXI4-Lite slave in front of a word-addressed SRAM array.
// Independent read and write channels, byte strobes, fixed access latency,
// and SLVERR for out-of-range or misaligned addresses.
//
// Handshake rule, identical on AR, R, AW, W and B: a transfer happens on the
// rising edge where valid and ready are both 1. A valid raised by this slave
// (rvalid, bvalid) stays high with a stable payload until that edge. The ready
// and valid outputs are decoded from registered state only, so no input
// reaches an output combinationally.
module ysyx_22041211_axi_lite_sram_rw #(
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DATA_LEN   = 32,
  parameter int                  DEPTH_LOG2 = 12,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                  RD_LATENCY = 1,
  parameter int                  WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_LEN-1:0]   araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_LEN-1:0]   rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_LEN-1:0]   awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_LEN-1:0]   wdata,
  input  logic [DATA_LEN/8-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            rd_state_dbg,
  output logic [1:0]            wr_state_dbg
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam int         STRB_LEN  = DATA_LEN / 8;
  localparam logic [7:0] RD_LOAD   = 8'(RD_LATENCY - 1);
  localparam logic [7:0] WR_LOAD   = 8'(WR_LATENCY - 1);
  localparam logic       RD_DIRECT = (RD_LATENCY == 1);
  localparam logic       WR_DIRECT = (WR_LATENCY == 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_t;

  // Out of range (below base or past the last word) or not word aligned.
  function automatic logic addr_err(input logic [ADDR_LEN-1:0] a);
    logic [ADDR_LEN-1:0] off;
    off = a - BASE_ADDR;
    addr_err = (a < BASE_ADDR) || ((off >> (DEPTH_LOG2 + 2)) != '0) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_LEN-1:0] a);
    logic [ADDR_LEN-1:0] off;
    off = (a - BASE_ADDR) >> 2;
    addr_idx = DEPTH_LOG2'(off);
  endfunction

  logic [DATA_LEN-1:0] mem [DEPTH];

  // Held low through reset so every ready reads 0 while rst is asserted.
  logic live;

  rd_state_t rd_state, rd_next;
  logic [ADDR_LEN-1:0] rd_addr_q;
  logic [7:0]          rd_cnt;
  logic                ar_fire, rd_sample, rd_err;
  logic [ADDR_LEN-1:0] rd_src_addr;
  logic [DATA_LEN-1:0] rd_word;

  wr_state_t wr_state, wr_next;
  logic                aw_held, w_held;
  logic [ADDR_LEN-1:0] aw_addr_q;
  logic [DATA_LEN-1:0] w_data_q;
  logic [STRB_LEN-1:0] w_strb_q;
  logic [7:0]          wr_cnt;
  logic                aw_fire, w_fire, wr_go, wr_commit, wr_err;
  logic [ADDR_LEN-1:0] wr_src_addr;
  logic [DATA_LEN-1:0] wr_src_data;
  logic [STRB_LEN-1:0] wr_src_strb;

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

  // Ready gate: rises on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_state <= R_IDLE;
    else      rd_state <= rd_next;
  end

  // Read FSM next state: latency 1 skips the wait state entirely.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_fire) rd_next = RD_DIRECT ? R_RESP : R_WAIT;
      R_WAIT:  if (rd_cnt == 8'd1) rd_next = R_RESP;
      R_RESP:  if (rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Read FSM outputs, decoded from state.
  always_comb begin
    arready = live && (rd_state == R_IDLE);
    rvalid  = (rd_state == R_RESP);
  end

  // Read sample strobe and source: the live address on the handshake edge
  // when latency is 1, the captured address otherwise.
  always_comb begin
    ar_fire     = arvalid && arready;
    rd_src_addr = (rd_state == R_IDLE) ? araddr : rd_addr_q;
    rd_sample   = (ar_fire && RD_DIRECT) || ((rd_state == R_WAIT) && (rd_cnt == 8'd1));
    rd_err      = addr_err(rd_src_addr);
    rd_word     = mem[addr_idx(rd_src_addr)];
  end

  // Read datapath: capture address, count down latency, latch the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_cnt    <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      if (ar_fire) begin
        rd_addr_q <= araddr;
        rd_cnt    <= RD_LOAD;
      end else if (rd_state == R_WAIT) begin
        rd_cnt <= rd_cnt - 8'd1;
      end
      if (rd_sample) begin
        rdata <= rd_err ? '0 : rd_word;
        rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_state <= W_IDLE;
    else      wr_state <= wr_next;
  end

  // Write FSM next state: leave idle once both AW and W are in hand.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_go) wr_next = WR_DIRECT ? W_RESP : W_WAIT;
      W_WAIT:  if (wr_cnt == 8'd1) wr_next = W_RESP;
      W_RESP:  if (bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write FSM outputs: each ready drops after its own capture.
  always_comb begin
    awready = live && (wr_state == W_IDLE) && !aw_held;
    wready  = live && (wr_state == W_IDLE) && !w_held;
    bvalid  = (wr_state == W_RESP);
  end

  // Write commit strobe and source: held values, or the ones arriving now.
  always_comb begin
    aw_fire     = awvalid && awready;
    w_fire      = wvalid && wready;
    wr_go       = (wr_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
    wr_commit   = (wr_go && WR_DIRECT) || ((wr_state == W_WAIT) && (wr_cnt == 8'd1));
    wr_src_addr = aw_held ? aw_addr_q : awaddr;
    wr_src_data = w_held ? w_data_q : wdata;
    wr_src_strb = w_held ? w_strb_q : wstrb;
    wr_err      = addr_err(wr_src_addr);
  end

  // Write datapath: independent AW/W capture, latency count, response code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wr_cnt    <= '0;
      bresp     <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (wr_go) wr_cnt <= WR_LOAD;
      else if (wr_state == W_WAIT) wr_cnt <= wr_cnt - 8'd1;
      if (wr_commit) bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if ((wr_state == W_RESP) && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // SRAM byte-lane write; a read sampled on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (wr_commit && !wr_err) begin
      for (int b = 0; b < STRB_LEN; b++) begin
        if (wr_src_strb[b]) mem[addr_idx(wr_src_addr)][8*b +: 8] <= wr_src_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_axi_lite_sram_rw.sv
// Self-checking bench for the AXI4-Lite SRAM slave: directed scenarios plus a
// randomized mix checked against a byte-level memory model.
module tb_ysyx_22041211_axi_lite_sram_rw;

  localparam int          RD_LAT     = 3;
  localparam int          WR_LAT     = 2;
  localparam int          DEPTH_LOG2 = 12;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam int          GUARD      = 50;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp, rd_state_dbg, wr_state_dbg;

  always #5 clk = ~clk;

  ysyx_22041211_axi_lite_sram_rw #(
    .ADDR_LEN(32), .DATA_LEN(32), .DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];

  function automatic bit ref_err(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH) || (a % 4 != 0);
  endfunction

  function automatic int ref_key(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!ref_err(a)) ref_mem[ref_key(a)] = merge(ref_mem[ref_key(a)], d, s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int guard, lat;
    araddr = addr; arvalid = 1'b1; guard = 0;
    while (!arready && guard < GUARD) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1; arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < GUARD) begin @(posedge clk); #1; lat++; end
    if (guard >= GUARD) lat = -1;
    n_cmp++;
    if (lat !== RD_LAT - 1) begin n_err++; $display("FAIL rd_latency addr=%h: got %0d want %0d", addr, lat, RD_LAT - 1); end
    data = rdata; resp = rresp;
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  // order: 0 = AW and W together, 1 = W first, 2 = AW first
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, output logic [1:0] resp);
    bit aw_acc, w_acc;
    int guard, lat;
    awaddr = addr; wdata = data; wstrb = strb;
    if (order == 0) begin awvalid = 1'b1; wvalid = 1'b1; end
    else if (order == 1) wvalid = 1'b1;
    else awvalid = 1'b1;
    guard = 0;
    while ((awvalid || wvalid) && guard < GUARD) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(posedge clk); #1; guard++;
      if (w_acc) begin
        wvalid = 1'b0;
        if (order == 1) begin
          n_cmp++;
          if (wready !== 1'b0 || awready !== 1'b1) begin
            n_err++; $display("FAIL w_first_ready: got wready=%b awready=%b want 0/1", wready, awready);
          end
          awvalid = 1'b1;
        end
      end
      if (aw_acc) begin
        awvalid = 1'b0;
        if (order == 2) wvalid = 1'b1;
      end
    end
    lat = 0;
    while (!bvalid && lat < GUARD) begin @(posedge clk); #1; lat++; end
    if (guard >= GUARD) lat = -1;
    n_cmp++;
    if (lat !== WR_LAT - 1) begin n_err++; $display("FAIL wr_latency addr=%h: got %0d want %0d", addr, lat, WR_LAT - 1); end
    resp = bresp;
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3 rst = 1'b0; #1;
    n_cmp++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      n_err++; $display("FAIL reset_outputs: got rdy=%b%b%b val=%b%b rdata=%h rresp=%b bresp=%b want all zero",
                        arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({arready, awready, wready} !== 3'b000) begin n_err++; $display("FAIL reset_held_ready: got %b want 000", {arready, awready, wready}); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
      n_err++; $display("FAIL reset_release: got %b want 11100", {arready, awready, wready, rvalid, bvalid});
    end
  endtask

  task automatic test_preload();
    logic [31:0] d; logic [1:0] r; logic [31:0] a;
    for (int w = 0; w < 17; w++) begin
      a = (w == 16) ? BASE + 4 * (DEPTH - 1) : BASE + 4 * w;
      d = (w == 0) ? 32'hDEAD_BEEF : $urandom;
      axi_write(a, d, 4'hF, $urandom_range(0, 2), r);
      ref_mem[ref_key(a)] = d;
      n_cmp++;
      if (r !== 2'b00) begin n_err++; $display("FAIL preload_bresp addr=%h: got %b want 00", a, r); end
    end
    axi_read(BASE, d, r);
    n_cmp++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin n_err++; $display("FAIL read_word0: got %h/%b want deadbeef/00", d, r); end
    axi_read(BASE + 4 * (DEPTH - 1), d, r);
    n_cmp++;
    if (d !== ref_mem[DEPTH - 1] || r !== 2'b00) begin n_err++; $display("FAIL read_last_word: got %h/%b want %h/00", d, r, ref_mem[DEPTH - 1]); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r;
    axi_write(BASE + 4, 32'hFFFF_FFFF, 4'hF, 0, r);
    axi_write(BASE + 4, 32'h1122_3344, 4'b0101, 1, r);
    ref_mem[1] = 32'hFF22_FF44;
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL strobe_bresp: got %b want 00", r); end
    axi_read(BASE + 4, d, r);
    n_cmp++;
    if (d !== 32'hFF22_FF44) begin n_err++; $display("FAIL strobe_readback: got %h want ff22ff44", d); end
    axi_write(BASE + 8, 32'h0BAD_0BAD, 4'b0000, 2, r);
    axi_read(BASE + 8, d, r);
    n_cmp++;
    if (d !== ref_mem[2] || r !== 2'b00) begin n_err++; $display("FAIL strobe_none: got %h want %h", d, ref_mem[2]); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r;
    axi_read(32'h7FFF_FFFC, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL err_read_below: got %h/%b want 0/10", d, r); end
    axi_read(32'h8000_0002, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL err_read_misaligned: got %h/%b want 0/10", d, r); end
    axi_write(BASE + 4 * DEPTH, 32'h1234_5678, 4'hF, 0, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL err_write_above: got %b want 10", r); end
    axi_write(BASE + 5, 32'h1234_5678, 4'hF, 1, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL err_write_misaligned: got %b want 10", r); end
    axi_read(BASE, d, r);
    n_cmp++;
    if (d !== ref_mem[0] || r !== 2'b00) begin n_err++; $display("FAIL err_word0_unchanged: got %h want %h", d, ref_mem[0]); end
    axi_read(BASE + 4, d, r);
    n_cmp++;
    if (d !== ref_mem[1]) begin n_err++; $display("FAIL err_word1_unchanged: got %h want %h", d, ref_mem[1]); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, e; logic [1:0] r; logic [3:0] s;
    int w, pick;
    for (int it = 0; it < 40; it++) begin
      w = $urandom_range(0, 15);
      pick = $urandom_range(0, 9);
      case (pick)
        0: a = BASE - 4 * $urandom_range(1, 4);
        1: a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
        2: a = BASE + 4 * w + $urandom_range(1, 3);
        default: a = BASE + 4 * w;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 2), r);
        ref_write(a, d, s);
        n_cmp++;
        if (r !== (ref_err(a) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL rand_bresp addr=%h: got %b", a, r); end
      end else begin
        exp_q.push_back(ref_err(a) ? 32'h0 : ref_mem[ref_key(a)]);
        axi_read(a, d, r);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e || r !== (ref_err(a) ? 2'b10 : 2'b00)) begin
          n_err++; $display("FAIL rand_read addr=%h: got %h/%b want %h/%b", a, d, r, e, ref_err(a) ? 2'b10 : 2'b00);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, bad;
    araddr = BASE + 12; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < GUARD) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== RD_LAT - 1) begin n_err++; $display("FAIL bp_rd_latency: got %0d want %0d", lat, RD_LAT - 1); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (rvalid !== 1'b1 || rdata !== ref_mem[3] || rresp !== 2'b00 || arready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL bp_read_hold: got %0d bad cycles want 0 (rdata=%h want %h)", bad, rdata, ref_mem[3]); end
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin n_err++; $display("FAIL bp_read_release: got rvalid=%b arready=%b want 0/1", rvalid, arready); end
    awaddr = BASE + 6; wdata = 32'h5555_AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < GUARD) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== WR_LAT - 1) begin n_err++; $display("FAIL bp_wr_latency: got %0d want %0d", lat, WR_LAT - 1); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL bp_write_hold: got %0d bad cycles want 0", bad); end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      n_err++; $display("FAIL bp_write_release: got bvalid=%b awready=%b wready=%b want 0/1/1", bvalid, awready, wready);
    end
  endtask

  // AR at edge N, AW+W at N+1: the read samples on the same edge the write commits.
  task automatic test_collision();
    logic [31:0] old_w, d; logic [1:0] r;
    old_w = ref_mem[4];
    araddr = BASE + 16; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    awaddr = BASE + 16; wdata = 32'hC0FF_EE00; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_w) begin
      n_err++; $display("FAIL collision_old: got rvalid=%b bvalid=%b rdata=%h want 1/1/%h", rvalid, bvalid, rdata, old_w);
    end
    rready = 1'b1; bready = 1'b1; @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    ref_mem[4] = 32'hC0FF_EE00;
    axi_read(BASE + 16, d, r);
    n_cmp++;
    if (d !== 32'hC0FF_EE00) begin n_err++; $display("FAIL collision_new: got %h want c0ffee00", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int seen;
    araddr = BASE + 20; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    rst = 1'b0; #1;
    n_cmp++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== 32'h0 || rresp !== 2'b00) begin
      n_err++; $display("FAIL rst_in_rwait: got rvalid=%b arready=%b rdata=%h want 0/0/0", rvalid, arready, rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (rvalid) seen++; end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rst_read_no_resp: got %0d rvalid cycles want 0", seen); end
    axi_write(BASE + 1, 32'h0, 4'hF, 0, r);
    awaddr = BASE + 24; wdata = ~ref_mem[6]; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b0; #1;
    n_cmp++;
    if (bvalid !== 1'b0 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
      n_err++; $display("FAIL rst_in_wwait: got bvalid=%b bresp=%b awready=%b wready=%b want 0", bvalid, bresp, awready, wready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (bvalid) seen++; end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rst_write_no_resp: got %0d bvalid cycles want 0", seen); end
    axi_read(BASE + 24, d, r);
    n_cmp++;
    if (d !== ref_mem[6]) begin n_err++; $display("FAIL rst_word_unchanged: got %h want %h", d, ref_mem[6]); end
    axi_read(BASE + 20, d, r);
    n_cmp++;
    if (d !== ref_mem[5] || r !== 2'b00) begin n_err++; $display("FAIL rst_read_retry: got %h/%b want %h/00", d, r, ref_mem[5]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_preload();
    test_strobe();
    test_errors();
    test_random();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached after %0d compares", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
